// File: rtl/go_pkg.sv
// rtl/go_pkg.sv - shared types and constants for the Go move controller
//
// Purpose : cell encoding, response codes, controller states and board
//           constants used by go_move_ctrl and go_coord_decode.
// Ports   : none (package).
// Config  : none.

package go_pkg;

    localparam int         BOARD_DIM = 9;
    localparam int         CELLS     = BOARD_DIM * BOARD_DIM;
    localparam logic [7:0] PASS_MOVE = 8'hFF;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLACK = 2'b01,
        WHITE = 2'b10
    } cell_t;

    typedef enum logic [2:0] {
        RESP_OK        = 3'd0,
        RESP_PASS      = 3'd1,
        RESP_OCCUPIED  = 3'd2,
        RESP_OFF_BOARD = 3'd3,
        RESP_GAME_OVER = 3'd4
    } resp_t;

    typedef enum logic [2:0] {
        INIT,
        CLEAR,
        IDLE,
        READ,
        CHECK,
        WRITE,
        RESP,
        OVER
    } state_t;

endpackage

// File: rtl/go_coord_decode.sv
// rtl/go_coord_decode.sv - combinational move coordinate decoder
//
// Purpose : splits a move byte into pass / in-bounds flags and the linear
//           board address row*9 + col.
// Ports   : move      [7:0]        in  [7:4] row, [3:0] col, 8'hFF = pass
//           in_bounds              out row and col both inside the board
//           is_pass                out move is the pass code
//           addr      [ADDR_W-1:0] out linear cell address
// Config  : none.

module go_coord_decode #(
    parameter int BOARD_DIM = 9,
    parameter int ADDR_W    = 7
) (
    input  logic [7:0]        move,
    output logic              in_bounds,
    output logic              is_pass,
    output logic [ADDR_W-1:0] addr
);
    import go_pkg::*;

    logic [3:0] row;
    logic [3:0] col;

    assign row       = move[7:4];
    assign col       = move[3:0];
    assign is_pass   = (move == PASS_MOVE);
    assign in_bounds = !is_pass
                       && ({28'd0, row} < BOARD_DIM)
                       && ({28'd0, col} < BOARD_DIM);

    // row*9 as a shift-add; out-of-bounds moves produce a don't-care address
    assign addr = (ADDR_W'(row) << 3) + ADDR_W'(row) + ADDR_W'(col);

endmodule

// File: rtl/go_move_ctrl.sv
// rtl/go_move_ctrl.sv - move sequencer between move source and 9x9 board store
//
// Purpose : clears the board, validates moves (bounds, occupancy via board
//           read), writes stones, alternates turns, tracks passes/game over.
// Ports   : clk_in, reset (async active-low), new_game (sync restart),
//           move/move_valid/move_ready (move source handshake),
//           rd_en/rd_addr/rd_data (board read, data one cycle after rd_en),
//           wr_en/wr_addr/wr_data (board write),
//           resp_valid/resp_code (one-cycle response), to_play, game_over, busy,
//           move_count (only with MOVE_CNT_EN).
// Config  : MOVE_CNT_EN adds an 8-bit saturating count of placed stones.

module go_move_ctrl #(
    parameter int BOARD_DIM = 9,
    parameter int ADDR_W    = 7
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              new_game,
    input  logic [7:0]        move,
    input  logic              move_valid,
    output logic              move_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        wr_data,
    output logic              resp_valid,
    output logic [2:0]        resp_code,
    output logic              to_play,
    output logic              game_over,
`ifdef MOVE_CNT_EN
    output logic [7:0]        move_count,
`endif
    output logic              busy
);
    import go_pkg::*;

    localparam int N_CELLS = BOARD_DIM * BOARD_DIM;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CELLS - 1);

    state_t            state_q, state_d;
    logic [1:0]        pass_cnt_q, pass_cnt_d;
    logic              rd_en_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [1:0]        wr_data_d;
    logic              resp_valid_d;
    logic [2:0]        resp_code_d;
    logic              to_play_d;
    logic              game_over_d;
    logic              busy_d;
`ifdef MOVE_CNT_EN
    logic [7:0]        move_count_d;
`endif

    logic              dec_in_bounds;
    logic              dec_is_pass;
    logic [ADDR_W-1:0] dec_addr;
    logic              accept;

    go_coord_decode #(
        .BOARD_DIM (BOARD_DIM),
        .ADDR_W    (ADDR_W)
    ) u_decode (
        .move      (move),
        .in_bounds (dec_in_bounds),
        .is_pass   (dec_is_pass),
        .addr      (dec_addr)
    );

    assign move_ready = ((state_q == IDLE) || (state_q == OVER)) && !new_game;
    assign accept     = move_valid && move_ready;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            pass_cnt_q <= 2'd0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 2'b00;
            resp_valid <= 1'b0;
            resp_code  <= 3'd0;
            to_play    <= 1'b0;
            game_over  <= 1'b0;
            busy       <= 1'b1;
`ifdef MOVE_CNT_EN
            move_count <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            pass_cnt_q <= pass_cnt_d;
            rd_en      <= rd_en_d;
            rd_addr    <= rd_addr_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            resp_valid <= resp_valid_d;
            resp_code  <= resp_code_d;
            to_play    <= to_play_d;
            game_over  <= game_over_d;
            busy       <= busy_d;
`ifdef MOVE_CNT_EN
            move_count <= move_count_d;
`endif
        end
    end

    // Next-state and next-output logic; every output register is loaded
    // from here so the board and response interfaces are glitch-free.
    always_comb begin
        state_d      = state_q;
        pass_cnt_d   = pass_cnt_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr;
        wr_data_d    = wr_data;
        resp_valid_d = 1'b0;
        resp_code_d  = resp_code;
        to_play_d    = to_play;
        game_over_d  = game_over;
`ifdef MOVE_CNT_EN
        move_count_d = move_count;
`endif

        if (new_game && (state_q != INIT)) begin
            // Restart drops any move in flight: no response, no stone write.
            state_d     = CLEAR;
            pass_cnt_d  = 2'd0;
            wr_en_d     = 1'b1;
            wr_addr_d   = '0;
            wr_data_d   = EMPTY;
            to_play_d   = 1'b0;
            game_over_d = 1'b0;
`ifdef MOVE_CNT_EN
            move_count_d = 8'd0;
`endif
        end else begin
            unique case (state_q)
                INIT: begin
                    state_d   = CLEAR;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = EMPTY;
                end
                CLEAR: begin
                    // wr_addr doubles as the clear counter
                    if (wr_addr == LAST_ADDR) begin
                        state_d = IDLE;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = wr_addr + 1'b1;
                        wr_data_d = EMPTY;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (dec_is_pass) begin
                            state_d      = RESP;
                            resp_valid_d = 1'b1;
                            resp_code_d  = RESP_PASS;
                            to_play_d    = !to_play;
                            pass_cnt_d   = pass_cnt_q + 2'd1;
                            if (pass_cnt_q == 2'd1) begin
                                game_over_d = 1'b1;
                            end
                        end else if (!dec_in_bounds) begin
                            state_d      = RESP;
                            resp_valid_d = 1'b1;
                            resp_code_d  = RESP_OFF_BOARD;
                        end else begin
                            state_d   = READ;
                            rd_en_d   = 1'b1;
                            rd_addr_d = dec_addr;
                        end
                    end
                end
                READ: begin
                    state_d = CHECK;
                end
                CHECK: begin
                    resp_valid_d = 1'b1;
                    if (rd_data == EMPTY) begin
                        state_d     = WRITE;
                        wr_en_d     = 1'b1;
                        wr_addr_d   = rd_addr;
                        wr_data_d   = to_play ? WHITE : BLACK;
                        resp_code_d = RESP_OK;
                        to_play_d   = !to_play;
                        pass_cnt_d  = 2'd0;
`ifdef MOVE_CNT_EN
                        if (move_count != 8'hFF) begin
                            move_count_d = move_count + 8'd1;
                        end
`endif
                    end else begin
                        state_d     = RESP;
                        resp_code_d = RESP_OCCUPIED;
                    end
                end
                WRITE, RESP: begin
                    // one dead cycle after every response keeps resp_valid a single pulse
                    state_d = game_over ? OVER : IDLE;
                end
                OVER: begin
                    if (accept) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_code_d  = RESP_GAME_OVER;
                    end
                end
                default: begin
                    state_d = INIT;
                end
            endcase
        end

        busy_d = (state_d == INIT) || (state_d == CLEAR);
    end

endmodule

// File: tb/tb_go_move_ctrl.sv
// tb/tb_go_move_ctrl.sv - self-checking bench for go_move_ctrl

module tb_go_move_ctrl;

    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic       new_game = 1'b0;
    logic [7:0] move = 8'h00;
    logic       move_valid = 1'b0;
    logic       move_ready;
    logic       rd_en;
    logic [6:0] rd_addr;
    logic [1:0] rd_data = 2'b00;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [1:0] wr_data;
    logic       resp_valid;
    logic [2:0] resp_code;
    logic       to_play;
    logic       game_over;
    logic       busy;

    go_move_ctrl #(.BOARD_DIM(9), .ADDR_W(7)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .new_game   (new_game),
        .move       (move),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .resp_valid (resp_valid),
        .resp_code  (resp_code),
        .to_play    (to_play),
        .game_over  (game_over),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // board store: one-cycle read latency
    logic [1:0] store [128];
    always @(posedge clk_in) begin
        if (wr_en) store[wr_addr] <= wr_data;
        if (rd_en) rd_data <= store[rd_addr];
    end

    typedef struct { logic [2:0] code; int due; } resp_exp_t;
    typedef struct { logic [6:0] addr; int due; } rd_exp_t;
    typedef struct { logic [6:0] addr; logic [1:0] data; int due; } wr_exp_t;

    resp_exp_t rq[$];
    rd_exp_t   rdq[$];
    wr_exp_t   wq[$];

    int total = 0;
    int bad = 0;

    // game model
    bit occ [81];
    bit tp_m = 1'b0;
    int passes_m = 0;
    bit over_m = 1'b0;

    resp_exp_t mre;
    rd_exp_t   mrd;
    wr_exp_t   mwr;

    always @(negedge clk_in) begin
        if (resp_valid) begin
            total++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected code=%0d cyc=%0d", resp_code, cyc);
            end else begin
                mre = rq.pop_front();
                if (resp_code !== mre.code || cyc !== mre.due) begin
                    bad++;
                    $display("FAIL resp code=%0d cyc=%0d required code=%0d cyc=%0d",
                             resp_code, cyc, mre.code, mre.due);
                end
            end
        end
        if (rd_en) begin
            total++;
            if (rdq.size() == 0) begin
                bad++;
                $display("FAIL read_unexpected addr=%0d cyc=%0d", rd_addr, cyc);
            end else begin
                mrd = rdq.pop_front();
                if (rd_addr !== mrd.addr || cyc !== mrd.due) begin
                    bad++;
                    $display("FAIL read addr=%0d cyc=%0d required addr=%0d cyc=%0d",
                             rd_addr, cyc, mrd.addr, mrd.due);
                end
            end
        end
        if (wr_en && !busy) begin
            total++;
            if (wq.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected addr=%0d data=%0d cyc=%0d", wr_addr, wr_data, cyc);
            end else begin
                mwr = wq.pop_front();
                if (wr_addr !== mwr.addr || wr_data !== mwr.data || cyc !== mwr.due) begin
                    bad++;
                    $display("FAIL write addr=%0d data=%0d cyc=%0d required addr=%0d data=%0d cyc=%0d",
                             wr_addr, wr_data, cyc, mwr.addr, mwr.data, mwr.due);
                end
            end
        end
    end

    task automatic model_new_game();
        for (int i = 0; i < 81; i++) occ[i] = 1'b0;
        tp_m = 1'b0;
        passes_m = 0;
        over_m = 1'b0;
    endtask

    task automatic check_sweep(output int start);
        int w = 0;
        @(negedge clk_in);
        while (!(wr_en && busy) && w < 10) begin
            @(negedge clk_in);
            w++;
        end
        start = cyc;
        for (int i = 0; i < 81; i++) begin
            total++;
            if (!(wr_en === 1'b1 && busy === 1'b1 && wr_addr === 7'(i)
                  && wr_data === 2'b00 && move_ready === 1'b0)) begin
                bad++;
                $display("FAIL clear_sweep[%0d] wr_en=%0b busy=%0b addr=%0d data=%0d ready=%0b required 1 1 %0d 0 0",
                         i, wr_en, busy, wr_addr, wr_data, move_ready, i);
            end
            if (i < 80) @(negedge clk_in);
        end
        @(negedge clk_in);
        total++;
        if (move_ready !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
            bad++;
            $display("FAIL after_sweep ready=%0b busy=%0b wr_en=%0b required 1 0 0",
                     move_ready, busy, wr_en);
        end
    endtask

    task automatic check_status(input string name);
        total++;
        if (to_play !== tp_m || game_over !== over_m) begin
            bad++;
            $display("FAIL %s to_play=%0b game_over=%0b required %0b %0b",
                     name, to_play, game_over, tp_m, over_m);
        end
    endtask

    task automatic send_move(input logic [7:0] m);
        int w = 0;
        int t;
        int a;
        @(negedge clk_in);
        while (!move_ready && w < 200) begin
            @(negedge clk_in);
            w++;
        end
        total++;
        if (!move_ready) begin
            bad++;
            $display("FAIL ready_timeout move=%h ready=%0b required 1", m, move_ready);
            return;
        end
        move = m;
        move_valid = 1'b1;
        t = cyc;
        if (over_m) begin
            rq.push_back('{3'd4, t + 1});
        end else if (m == 8'hFF) begin
            rq.push_back('{3'd1, t + 1});
            tp_m = !tp_m;
            passes_m++;
            if (passes_m >= 2) over_m = 1'b1;
        end else if (m[7:4] > 4'd8 || m[3:0] > 4'd8) begin
            rq.push_back('{3'd3, t + 1});
        end else begin
            a = int'(m[7:4]) * 9 + int'(m[3:0]);
            rdq.push_back('{7'(a), t + 1});
            if (occ[a]) begin
                rq.push_back('{3'd2, t + 3});
            end else begin
                rq.push_back('{3'd0, t + 3});
                wq.push_back('{7'(a), tp_m ? 2'b10 : 2'b01, t + 3});
                occ[a] = 1'b1;
                tp_m = !tp_m;
                passes_m = 0;
            end
        end
        @(posedge clk_in);
        #1 move_valid = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic test_reset();
        int s;
        repeat (3) @(negedge clk_in);
        total++;
        if ({to_play, game_over, resp_valid, resp_code, wr_en, rd_en, rd_addr, wr_addr,
             wr_data, move_ready, busy} !== {1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0,
             2'b00, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_outputs tp=%0b go=%0b rv=%0b rc=%0d we=%0b re=%0b ra=%0d wa=%0d wd=%0d rdy=%0b busy=%0b required all 0 busy 1",
                     to_play, game_over, resp_valid, resp_code, wr_en, rd_en, rd_addr, wr_addr,
                     wr_data, move_ready, busy);
        end
        reset = 1'b1;
        model_new_game();
        check_sweep(s);
        check_status("reset_status");
    endtask

    task automatic test_place();
        send_move(8'h00);
        check_status("place_00");
        send_move(8'h88);
        check_status("place_88");
    endtask

    task automatic test_occupied();
        send_move(8'h44);
        check_status("place_44");
        send_move(8'h44);
        check_status("occupied_44");
    endtask

    task automatic test_off_board();
        send_move(8'h49);
        check_status("off_49");
        send_move(8'h3A);
        check_status("off_3A");
    endtask

    task automatic test_pass_over();
        int s;
        send_move(8'hFF);
        check_status("pass_1");
        send_move(8'hFF);
        check_status("pass_2");
        send_move(8'h00);
        check_status("over_move");
        @(negedge clk_in);
        new_game = 1'b1;
        @(posedge clk_in);
        #1 new_game = 1'b0;
        model_new_game();
        check_sweep(s);
        check_status("new_game_status");
    endtask

    task automatic test_pass_cleared();
        send_move(8'hFF);
        send_move(8'h22);
        send_move(8'hFF);
        check_status("pass_place_pass");
    endtask

    task automatic test_new_game_mid();
        int t;
        int s;
        int w = 0;
        @(negedge clk_in);
        while (!move_ready && w < 200) begin
            @(negedge clk_in);
            w++;
        end
        move = 8'h55;
        move_valid = 1'b1;
        t = cyc;
        rdq.push_back('{7'd50, t + 1});
        @(posedge clk_in);
        #1 move_valid = 1'b0;
        @(posedge clk_in);
        #1 new_game = 1'b1;
        @(posedge clk_in);
        #1 new_game = 1'b0;
        model_new_game();
        check_sweep(s);
        total++;
        if (s !== t + 3) begin
            bad++;
            $display("FAIL new_game_mid_sweep_start cyc=%0d required %0d", s, t + 3);
        end
        check_status("new_game_mid_status");
    endtask

    task automatic test_back_to_back();
        send_move(8'h10);
        send_move(8'h11);
        check_status("back_to_back");
    endtask

    initial begin
        test_reset();
        test_place();
        test_occupied();
        test_off_board();
        test_pass_over();
        test_pass_cleared();
        test_new_game_mid();
        test_back_to_back();
        repeat (4) @(negedge clk_in);
        total++;
        if (rq.size() != 0 || rdq.size() != 0 || wq.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected resp=%0d rd=%0d wr=%0d required 0 0 0",
                     rq.size(), rdq.size(), wq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/go_move_ctrl.md
Name: go_move_ctrl

Overview:
- Sequencer between the move source (move/move_valid) and the 9x9 Go board store (2-bit cells, one read port and one write port).
- Clears the board at reset and on new_game; accepts one move at a time and checks bounds and occupancy by reading the board.
- Writes the stone for the side to play, alternates turns, handles passes and declares game over after two consecutive passes.

Parameters:
- BOARD_DIM, 9, board edge length in cells.
- ADDR_W, 7, width of the linear cell address; addr = row*BOARD_DIM + col.

Ports:
- clk_in  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- new_game  input  1  synchronous restart request, level-sampled.
- move  input  8  [7:4] row, [3:0] col; 8'hFF = pass.
- move_valid  input  1  move offered.
- move_ready  output  1  controller can accept a move this cycle.
- rd_en  output  1  board read strobe.
- rd_addr  output  ADDR_W  board read address.
- rd_data  input  2  cell read data, valid one cycle after rd_en.
- wr_en  output  1  board write strobe.
- wr_addr  output  ADDR_W  board write address.
- wr_data  output  2  cell value written.
- resp_valid  output  1  one-cycle response pulse.
- resp_code  output  3  0 OK, 1 PASS, 2 OCCUPIED, 3 OFF_BOARD, 4 GAME_OVER.
- to_play  output  1  0 black, 1 white.
- game_over  output  1  two consecutive passes have occurred.
- busy  output  1  high in INIT and CLEAR.

Behaviour:
- Reset (reset low, asynchronous): state INIT, clear counter 0, pass count 0. Outputs: to_play 0, game_over 0, resp_valid 0, resp_code 0, wr_en 0, rd_en 0, all addresses 0, wr_data 0, move_ready 0, busy 1.
- All outputs are registered except move_ready.
- move_ready = (state is IDLE or OVER) and not new_game.
- A move is accepted on any cycle with move_valid and move_ready both high.
- INIT -> CLEAR on the first edge after reset release.
- CLEAR: wr_en 1, wr_data 2'b00, wr_addr counts 0..80 (81 cycles), then IDLE. busy is low from IDLE onward.
- IDLE, on accept at cycle T:
  - Pass: resp PASS at T+1; to_play toggles; pass count increments. On reaching 2: game_over 1 and state OVER; otherwise back to IDLE.
  - Row > 8 or col > 8 (and not 8'hFF): resp OFF_BOARD at T+1; no read; to_play unchanged.
  - Otherwise: READ at T+1 (rd_en 1, rd_addr = row*9 + col computed as (row<<3) + row + col), CHECK at T+2.
    - rd_data == 00: WRITE at T+3 with wr_en 1, wr_data = 01 if to_play is 0 else 10, resp OK. to_play toggles and pass count clears.
    - rd_data != 00: resp OCCUPIED at T+3; no write.
  - Next accept possible at T+2 for pass and off-board moves, T+4 for placed or occupied moves.
- OVER: every accepted move gets resp GAME_OVER at T+1; no reads or writes; game_over stays 1.
- new_game (highest priority, any state except INIT): next state CLEAR with counter 0. to_play 0, pass count 0, game_over 0.
  - Any in-flight move is dropped with no response and no write.
  - A move_valid in the same cycle is not accepted, because move_ready is low.
- resp_valid has no backpressure and is never high in two consecutive cycles.
- Reset asserted mid-CLEAR or mid-move: immediate return to reset values; the clear restarts from address 0.

Optional Feature:
- MOVE_CNT_EN defined: adds output move_count (8 bits).
  - Reset value 0; cleared on new_game.
  - Increments on each OK response; saturates at 255; passes are not counted.
- MOVE_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package go_pkg:
  - cell_t: EMPTY 2'b00, BLACK 2'b01, WHITE 2'b10.
  - BOARD_DIM = 9, CELLS = 81, PASS_MOVE = 8'hFF.
  - resp_t enum holding the five response codes.
  - state_t enum: INIT, CLEAR, IDLE, READ, CHECK, WRITE, RESP, OVER.
- Sub-module go_coord_decode (combinational): move -> {in_bounds, is_pass, linear addr}. It is reused by later board-logic blocks.

Test Plan:
- Reset release -> exactly 81 cycles of wr_en with wr_data 00 and wr_addr 0..80; move_ready first high on the cycle after address 80; busy low; to_play 0.
- Accept move 8'h00, board model returns 00 -> rd_addr 0 at T+1; wr_en, wr_addr 0, wr_data 01 and resp OK at T+3; to_play becomes 1. Then move 8'h88 -> wr_addr 80, wr_data 10.
- Repeat move 8'h44 after it has been placed (rd_data 01) -> resp OCCUPIED at T+3, no wr_en, to_play unchanged.
- Move 8'h49 -> resp OFF_BOARD at T+1, no rd_en.
- Move 8'h3A -> resp OFF_BOARD at T+1, no rd_en.
- Pass, pass -> PASS, PASS, game_over 1. Next move 8'h00 -> GAME_OVER, no write. Then new_game -> CLEAR sweep, game_over 0, to_play 0.
- Pass, then legal placement, then pass -> game_over stays 0 (pass count cleared).
- Pulse new_game during CHECK -> no resp_valid, no WRITE, and the clear sweep starts the next cycle.
